hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hs_match.sv | 37 +++
 rtl/hazard_scoreboard.sv | 135 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and width helpers for the in-order hazard scoreboard.
// A slot records one in-flight register writer behind decode.
package hazard_pkg;

  localparam int MAX_REG_W = 8;
  localparam int FWD_NONE  = 0;

  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] rd;
    logic                 is_load;
  } slot_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int reg_w_of(input int num_regs);
    return clog2_min1(num_regs);
  endfunction

  // Width able to hold a slot index 1..depth.
  function automatic int slot_idx_w(input int depth);
    return clog2_min1(depth + 1);
  endfunction

endpackage

// File: rtl/hs_match.sv
// Priority match of one decode source against the in-flight slot chain.
// Reports the youngest (lowest-index) matching slot and whether it is a load.
module hs_match
  import hazard_pkg::*;
#(
  parameter int DEPTH   = 3,
  parameter int REG_W   = 5,
  parameter int R0_ZERO = 0,
  localparam int K_W    = slot_idx_w(DEPTH)
) (
  input  logic                    used,
  input  logic [REG_W-1:0]        src,
  input  slot_t [DEPTH-1:0]       slots,
  output logic                    hit,
  output logic [K_W-1:0]          k,
  output logic                    is_load
);

  logic src_live;

  assign src_live = used && !((R0_ZERO != 0) && (src == '0));

  // Scan oldest to youngest so the youngest match overwrites the result.
  always_comb begin
    hit     = 1'b0;
    k       = '0;
    is_load = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (src_live && slots[i].valid && (slots[i].rd == MAX_REG_W'(src))) begin
        hit     = 1'b1;
        k       = K_W'(i + 1);
        is_load = slots[i].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight writers in a shift chain and
// produces load-use stalls, writeback bypass and registered EX forward selects.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int FWD_EN   = 1,
  parameter int R0_ZERO  = 0,
  localparam int REG_W   = reg_w_of(NUM_REGS),
  localparam int FWD_W   = clog2_min1(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic [1:0]          id_src_used,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_reg_write,
  input  logic                id_is_load,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          id_byp,
  output logic [FWD_W-1:0]    ex_fwd_a,
  output logic [FWD_W-1:0]    ex_fwd_b,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [15:0]         stall_count
);

  localparam int K_W = slot_idx_w(DEPTH);
  localparam logic [K_W-1:0]   DEPTH_K    = K_W'(DEPTH);
  localparam logic [K_W-1:0]   LOAD_LAT_K = K_W'(LOAD_LAT);
  localparam logic [FWD_W-1:0] FWD_NONE_W = FWD_W'(FWD_NONE);

  slot_t [DEPTH-1:0] chain_q, chain_d;
  logic [FWD_W-1:0]  ex_fwd_a_q, ex_fwd_a_d;
  logic [FWD_W-1:0]  ex_fwd_b_q, ex_fwd_b_d;
  logic [15:0]       stall_count_q, stall_count_d;

  logic           hit_a, hit_b, ld_a, ld_b;
  logic [K_W-1:0] k_a, k_b;
  logic           load_use_a, load_use_b;
  logic           stall_c, insert;
  logic [1:0]     byp_c;

  hs_match #(.DEPTH(DEPTH), .REG_W(REG_W), .R0_ZERO(R0_ZERO)) u_match_a (
    .used    (id_valid & id_src_used[0]),
    .src     (id_rs1),
    .slots   (chain_q),
    .hit     (hit_a),
    .k       (k_a),
    .is_load (ld_a)
  );

  hs_match #(.DEPTH(DEPTH), .REG_W(REG_W), .R0_ZERO(R0_ZERO)) u_match_b (
    .used    (id_valid & id_src_used[1]),
    .src     (id_rs2),
    .slots   (chain_q),
    .hit     (hit_b),
    .k       (k_b),
    .is_load (ld_b)
  );

  assign load_use_a = hit_a && ld_a && (k_a < LOAD_LAT_K);
  assign load_use_b = hit_b && ld_b && (k_b < LOAD_LAT_K);

  // Decode handshake: the decode instruction is accepted on a cycle with
  // id_valid=1 and stall=0; flush discards it and overrides stall/bypass.
  always_comb begin
    stall_c = 1'b0;
    byp_c   = 2'b00;
    if (id_valid && !flush) begin
      if (FWD_EN != 0) begin
        stall_c  = load_use_a || load_use_b;
        byp_c[0] = !stall_c && hit_a && (k_a == DEPTH_K);
        byp_c[1] = !stall_c && hit_b && (k_b == DEPTH_K);
      end else begin
        stall_c = hit_a || hit_b;
      end
    end
  end

  always_comb begin
    ex_fwd_a_d = FWD_NONE_W;
    ex_fwd_b_d = FWD_NONE_W;
    if ((FWD_EN != 0) && id_valid && !flush && !stall_c) begin
      if (hit_a && (k_a != DEPTH_K)) ex_fwd_a_d = FWD_W'(k_a);
      if (hit_b && (k_b != DEPTH_K)) ex_fwd_b_d = FWD_W'(k_b);
    end

    insert = id_valid && id_reg_write && !stall_c && !flush &&
             !((R0_ZERO != 0) && (id_rd == '0));
    chain_d[0].valid   = insert;
    chain_d[0].rd      = insert ? MAX_REG_W'(id_rd) : '0;
    chain_d[0].is_load = insert && id_is_load;
    for (int i = 1; i < DEPTH; i++) begin
      chain_d[i] = chain_q[i-1];
    end

    stall_count_d = stall_count_q;
    if (stall_c && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (chain_q[i].valid) busy_mask[chain_q[i].rd[REG_W-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q       <= '0;
      ex_fwd_a_q    <= FWD_NONE_W;
      ex_fwd_b_q    <= FWD_NONE_W;
      stall_count_q <= '0;
    end else begin
      chain_q       <= chain_d;
      ex_fwd_a_q    <= ex_fwd_a_d;
      ex_fwd_b_q    <= ex_fwd_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall       = stall_c;
  assign id_byp      = byp_c;
  assign ex_fwd_a    = ex_fwd_a_q;
  assign ex_fwd_b    = ex_fwd_b_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: two configurations share one decode
// stream; a reference model queues expected outputs and a monitor compares.
module tb_hazard_scoreboard;

  localparam int EXP_W = 114;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_reg_write, id_is_load, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_src_used;

  logic        stall0, stall1;
  logic [1:0]  byp0, byp1;
  logic [1:0]  fa0, fb0;
  logic [2:0]  fa1, fb1;
  logic [31:0] busy0, busy1;
  logic [15:0] cnt0, cnt1;

  int checks = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q[$];

  hazard_scoreboard #(.NUM_REGS(32), .DEPTH(3), .LOAD_LAT(2), .FWD_EN(1), .R0_ZERO(0)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_src_used(id_src_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .flush(flush), .stall(stall0), .id_byp(byp0),
    .ex_fwd_a(fa0), .ex_fwd_b(fb0), .busy_mask(busy0), .stall_count(cnt0)
  );

  hazard_scoreboard #(.NUM_REGS(32), .DEPTH(6), .LOAD_LAT(4), .FWD_EN(0), .R0_ZERO(1)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_src_used(id_src_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .flush(flush), .stall(stall1), .id_byp(byp1),
    .ex_fwd_a(fa1), .ex_fwd_b(fb1), .busy_mask(busy1), .stall_count(cnt1)
  );

  // Reference model: per configuration, a list of in-flight writers by age.
  bit m_v[2][7];
  int m_rd[2][7];
  bit m_ld[2][7];
  int m_fa[2], m_fb[2], m_cnt[2];

  function automatic int p_depth(input int d);  return (d == 0) ? 3 : 6; endfunction
  function automatic int p_ll(input int d);     return (d == 0) ? 2 : 4; endfunction
  function automatic bit p_fe(input int d);     return (d == 0); endfunction
  function automatic bit p_rz(input int d);     return (d != 0); endfunction

  task automatic model_cycle(input int d, output logic [56:0] rec);
    int depth, ll;
    bit fe, rz, st, ins;
    int src[2];
    bit hit[2];
    int k[2];
    int nf[2];
    logic [1:0] byp;
    logic [31:0] busy;
    depth = p_depth(d); ll = p_ll(d); fe = p_fe(d); rz = p_rz(d);
    src[0] = int'(id_rs1);
    src[1] = int'(id_rs2);
    for (int i = 0; i < 2; i++) begin
      hit[i] = 0; k[i] = 0;
      if (id_valid && id_src_used[i] && !(rz && src[i] == 0))
        for (int j = 1; j <= depth; j++)
          if (!hit[i] && m_v[d][j] && m_rd[d][j] == src[i]) begin
            hit[i] = 1; k[i] = j;
          end
    end
    st = 0;
    if (id_valid && !flush)
      for (int i = 0; i < 2; i++)
        if (hit[i] && (!fe || (m_ld[d][k[i]] && k[i] < ll))) st = 1;
    byp = 2'b00; nf[0] = 0; nf[1] = 0;
    if (fe && id_valid && !flush && !st)
      for (int i = 0; i < 2; i++)
        if (hit[i]) begin
          if (k[i] == depth) byp[i] = 1'b1;
          else nf[i] = k[i];
        end
    busy = '0;
    for (int j = 1; j <= depth; j++) if (m_v[d][j]) busy[m_rd[d][j]] = 1'b1;
    ins = id_valid && id_reg_write && !st && !flush && !(rz && id_rd == 0);
    if (rst) begin
      for (int j = 1; j <= 6; j++) m_v[d][j] = 0;
      m_fa[d] = 0; m_fb[d] = 0; m_cnt[d] = 0;
    end else begin
      for (int j = depth; j >= 2; j--) begin
        m_v[d][j] = m_v[d][j-1]; m_rd[d][j] = m_rd[d][j-1]; m_ld[d][j] = m_ld[d][j-1];
      end
      m_v[d][1] = ins; m_rd[d][1] = int'(id_rd); m_ld[d][1] = id_is_load;
      m_fa[d] = nf[0]; m_fb[d] = nf[1];
      if (st && m_cnt[d] < 65535) m_cnt[d]++;
    end
    rec = {st, byp, busy, 3'(m_fa[d]), 3'(m_fb[d]), 16'(m_cnt[d])};
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      if (failures <= 20) $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  task automatic check_comb(input int d, input logic [56:0] rec);
    check($sformatf("dut%0d_stall", d), 32'((d == 0) ? stall0 : stall1), 32'(rec[56]));
    check($sformatf("dut%0d_id_byp", d), 32'((d == 0) ? byp0 : byp1), 32'(rec[55:54]));
    check($sformatf("dut%0d_busy_mask", d), (d == 0) ? busy0 : busy1, rec[53:22]);
  endtask

  task automatic check_reg(input int d, input logic [56:0] rec);
    check($sformatf("dut%0d_ex_fwd_a", d), 32'((d == 0) ? {1'b0, fa0} : fa1), 32'(rec[21:19]));
    check($sformatf("dut%0d_ex_fwd_b", d), 32'((d == 0) ? {1'b0, fb0} : fb1), 32'(rec[18:16]));
    check($sformatf("dut%0d_stall_count", d), 32'((d == 0) ? cnt0 : cnt1), 32'(rec[15:0]));
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input bit [1:0] used,
                       input int rdi, input bit rw, input bit ld, input bit fl, input bit r);
    logic [56:0] rec0, rec1;
    @(negedge clk);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_src_used = used;
    id_rd = 5'(rdi); id_reg_write = rw; id_is_load = ld; flush = fl; rst = r;
    model_cycle(0, rec0);
    model_cycle(1, rec1);
    exp_q.push_back({rec0, rec1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  // Monitor: combinational outputs just before the edge, registered ones just after.
  initial begin
    logic [EXP_W-1:0] cur;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        check_comb(0, cur[113:57]);
        check_comb(1, cur[56:0]);
        @(posedge clk);
        #1;
        check_reg(0, cur[113:57]);
        check_reg(1, cur[56:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_src_used = 0;
    id_rd = 0; id_reg_write = 0; id_is_load = 0; flush = 0;
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 7; j++) begin m_v[d][j] = 0; m_rd[d][j] = 0; m_ld[d][j] = 0; end
      m_fa[d] = 0; m_fb[d] = 0; m_cnt[d] = 0;
    end
    repeat (2) @(posedge clk);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
    idle(1);
    // ALU producer then immediate reader (rs1 and rs2 sides)
    drive(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    drive(1, 3, 0, 2'b01, 8, 1, 0, 0, 0);
    idle(7);
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0, 0);
    drive(1, 0, 4, 2'b10, 8, 1, 0, 0, 0);
    idle(7);
    // load-use: consumer held for one stalled cycle
    drive(1, 1, 0, 2'b01, 5, 1, 1, 0, 0);
    drive(1, 5, 0, 2'b01, 10, 1, 0, 0, 0);
    drive(1, 5, 0, 2'b01, 10, 1, 0, 0, 0);
    idle(7);
    // producer at the last slot: writeback bypass
    drive(1, 0, 0, 2'b00, 7, 1, 0, 0, 0);
    drive(1, 0, 0, 2'b00, 11, 1, 0, 0, 0);
    drive(1, 0, 0, 2'b00, 12, 1, 0, 0, 0);
    drive(1, 7, 7, 2'b11, 13, 1, 0, 0, 0);
    idle(7);
    // flush on top of a load-use hazard
    drive(1, 1, 0, 2'b01, 5, 1, 1, 0, 0);
    drive(1, 5, 0, 2'b01, 9, 1, 0, 1, 0);
    idle(7);
    // register 0 as destination and source
    drive(1, 0, 0, 2'b00, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 2'b11, 14, 1, 0, 0, 0);
    idle(7);
    // reset with a full chain
    drive(1, 0, 0, 2'b00, 1, 1, 0, 0, 0);
    drive(1, 0, 0, 2'b00, 2, 1, 1, 0, 0);
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0, 0);
    drive(1, 2, 4, 2'b11, 6, 1, 0, 0, 1);
    drive(1, 2, 4, 2'b11, 6, 1, 0, 0, 0);
    idle(7);
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            2'($urandom_range(0, 3)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
    end
    // self-dependent stream keeps the stall-only configuration stalling until saturation
    for (int i = 0; i < 77000; i++) drive(1, 3, 0, 2'b01, 3, 1, 0, 0, 0);
    idle(4);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
